timer_periph: RTL
=================

# timer_periph

Timer peripheral for the memory-mapped I/O bus. It sits behind the address decoder's timer control register (0x0000_2018) and timer done register (0x0000_201C). A CPU store to the control register loads a tick count and starts a countdown. The peripheral raises a sticky done flag that the CPU polls with loads. A free-running prescaler converts clock cycles into timer ticks.

## Interface
- `TICK_DIV`, default 100_000: clock cycles per tick in synthesis (1 ms at 100 MHz); must be ≥ 1.
- `SIM_DIV`, default 4: clock cycles per tick when `Simulacion` = 1; must be ≥ 1.
- `Simulacion`, default 0: selects `SIM_DIV` (1) or `TICK_DIV` (0) as the effective divider DIV.

Ports:
- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `TIMER_ctrl_wdata` input 32: control word.
  - bit 31 = START.
  - bits [30:0] = K, the tick count.
- `TIMER_ctrl_we` input 1: one-cycle write strobe from the address decoder; samples `TIMER_ctrl_wdata` at the rising edge.
- `TIMER_done_rdata` output 32: status word, all combinational from registered state.
  - bit 0 = DONE.
  - bit 1 = BUSY.
  - bits [31:2] = 0.
- `TIMER_count_rdata` output 32: {1'b0, remaining[30:0]}; debug/readback; not yet decoded.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: BUSY = 0, DONE = 0.
  - RUN: BUSY = 1, DONE = 0.
  - DONE: BUSY = 0, DONE = 1.
- Reset:
  - state = IDLE, remaining = 0, prescaler = 0.
  - All outputs read 0.
  - Reset has priority over a simultaneous write.
- Write with START = 1, from any state (restart semantics):
  - remaining ← K, prescaler ← 0.
  - Next state = RUN if K ≠ 0, else DONE.
  - A write in DONE clears DONE.
- Write with START = 0, from any state:
  - state ← IDLE, remaining ← 0, prescaler ← 0.
  - This clears DONE and aborts any countdown.
- RUN, no write:
  - Prescaler counts 0..DIV−1 and wraps; a tick occurs on the cycle where prescaler = DIV−1.
  - On a tick, remaining decrements by 1.
  - If remaining = 1 at the tick, remaining becomes 0 and state ← DONE.
  - With DIV = 1, every RUN cycle is a tick.
- DONE is sticky: it holds until the next control write or reset. Reads never clear it; the decoder has no read strobe.
- IDLE/DONE, no write: prescaler held at 0, remaining held.
- Width rules:
  - remaining is 31 bits unsigned and never underflows (no decrement at 0).
  - Prescaler width = $clog2(max(TICK_DIV, SIM_DIV)) + 1 and compares against DIV−1 only.
- Write during the tick cycle: the write wins; the tick is discarded.

## Timing
- Write sampled at edge E0, START = 1, K ≥ 1:
  - BUSY = 1 after E0.
  - DONE = 1, BUSY = 0 after edge E0 + K·DIV, i.e. exactly K·DIV cycles after the write edge.
- K = 0: DONE = 1 after E0, a 1-cycle latency; BUSY never asserts.
- Stop write at E0: DONE = BUSY = 0 after E0.
- `TIMER_count_rdata` updates on the tick edge; it reads K after E0 and reaches 0 at the DONE edge.
- No combinational path from the inputs to the outputs.
- Maximum duration: (2^31 − 1)·DIV cycles.

## Test plan
- Reset: assert `reset` for 2 cycles mid-stream → all outputs 0x0000_0000 on the first edge with reset high.
- Basic count: `Simulacion` = 1, `SIM_DIV` = 4; write 0x8000_0003 → `TIMER_done_rdata` = 0x2 for 11 cycles, then = 0x1 from cycle 12 and holding; count reads 3, 2, 1, 0 at cycles 0, 4, 8, 12.
- Zero count: write 0x8000_0000 → `TIMER_done_rdata` = 0x1 one edge later; BUSY is never seen.
- Restart mid-run:
  - Write 0x8000_0005; at cycle 9, write 0x8000_0002 → DONE exactly 8 cycles after the second write.
  - Also place a write on a tick cycle and confirm the tick is not applied.
- Stop and clear: run to DONE, then write 0x0000_0007 → status 0x0 next cycle and count 0; status stays 0 for 50 cycles.
- Reset mid-run: start K = 10, assert `reset` at cycle 6 → IDLE with all outputs 0; a fresh write 0x8000_0001 afterwards gives DONE at 4 cycles.

Source files
------------

// File: rtl/timer_periph_if.sv
// Control/status bus between the address decoder and the timer peripheral.
// Latency: pure wiring, no state.
// Backpressure: none; the write strobe is accepted every cycle.
interface timer_periph_if;
   logic [31:0] TIMER_ctrl_wdata;
   logic        TIMER_ctrl_we;
   logic [31:0] TIMER_done_rdata;
   logic [31:0] TIMER_count_rdata;

   // Decoder/CPU side: drives the control write, observes status
   modport master (
      output TIMER_ctrl_wdata,
      output TIMER_ctrl_we,
      input  TIMER_done_rdata,
      input  TIMER_count_rdata
   );

   // Timer side: accepts the control write, returns status
   modport slave (
      input  TIMER_ctrl_wdata,
      input  TIMER_ctrl_we,
      output TIMER_done_rdata,
      output TIMER_count_rdata
   );
endinterface

// File: rtl/timer_periph.sv
// Countdown timer: control write loads K ticks, sticky DONE after K*DIV cycles.
// Latency: status/count reflect a write one edge later; outputs are registered.
// Backpressure: none; every write is accepted and restarts or stops the timer.
module timer_periph #(
   parameter int TICK_DIV   = 100_000,
   parameter int SIM_DIV    = 4,
   parameter bit Simulacion = 1'b0
) (
   input logic           clk,
   input logic           reset,
   timer_periph_if.slave bus
);

   localparam int DIV  = Simulacion ? SIM_DIV : TICK_DIV;
   localparam int MAXD = (TICK_DIV > SIM_DIV) ? TICK_DIV : SIM_DIV;
   localparam int PW   = $clog2(MAXD) + 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [30:0]   remaining_q;
   logic [PW-1:0] presc_q;
   logic          busy_q;
   logic          done_q;

   logic          start_d;
   logic [30:0]   k_d;
   logic          tick_d;

   assign start_d = bus.TIMER_ctrl_wdata[31];
   assign k_d     = bus.TIMER_ctrl_wdata[30:0];
   assign tick_d  = (presc_q == PRESC_LAST);

   // Control FSM: a write always wins over a tick in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         presc_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (bus.TIMER_ctrl_we) begin
         presc_q <= '0;
         if (start_d) begin
            remaining_q <= k_d;
            if (k_d != '0) begin
               state_q <= RUN;
               busy_q  <= 1'b1;
               done_q  <= 1'b0;
            end else begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end else begin
            state_q     <= IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (tick_d) begin
                  presc_q <= '0;
                  if (remaining_q <= 31'd1) begin
                     remaining_q <= '0;
                     state_q     <= DONE;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                  end else begin
                     remaining_q <= remaining_q - 31'd1;
                  end
               end else begin
                  presc_q <= presc_q + PW'(1);
               end
            end
            // IDLE and DONE hold remaining and keep the prescaler parked
            default: presc_q <= '0;
         endcase
      end
   end

   assign bus.TIMER_done_rdata  = {30'd0, busy_q, done_q};
   assign bus.TIMER_count_rdata = {1'b0, remaining_q};

endmodule
